// File: rtl/riscv_test_pkg.sv
// Shared types for the RISC-V checkpoint checker: FSM state encoding and FAIL_CODE values.
package riscv_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_MISSED   = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

endpackage

// File: rtl/riscv_test_table.sv
// Checkpoint table: NUM_TEST entries of (instruction count, expected answer, valid),
// one write port, every entry exposed in parallel for the compare logic.
module riscv_test_table
    import riscv_test_pkg::*;
#(
    parameter int NUM_TEST = 32,
    parameter int DWIDTH   = 32,
    parameter int CWIDTH   = 32,
    parameter int IW       = 5
) (
    input  logic                             CLK,
    input  logic                             RSTn,
    input  logic                             wr_en,
    input  logic [IW-1:0]                    wr_idx,
    input  logic [CWIDTH-1:0]                wr_num_inst,
    input  logic [DWIDTH-1:0]                wr_ans,
    input  logic                             wr_valid,
    output logic [NUM_TEST-1:0][CWIDTH-1:0]  ent_num_inst,
    output logic [NUM_TEST-1:0][DWIDTH-1:0]  ent_ans,
    output logic [NUM_TEST-1:0]              ent_valid
);

    // Indices past the end of the table are silently dropped.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ent_num_inst <= '0;
            ent_ans      <= '0;
            ent_valid    <= '0;
        end else if (wr_en && (32'(wr_idx) < 32'(NUM_TEST))) begin
            ent_num_inst[wr_idx] <= wr_num_inst;
            ent_ans[wr_idx]      <= wr_ans;
            ent_valid[wr_idx]    <= wr_valid;
        end
    end

endmodule

// File: rtl/riscv_test_checker.sv
// Self-checking monitor: compares OUTPUT_PORT against a checkpoint table as NUM_INST advances.
// Optional cycle watchdog is compiled in when RISCV_TEST_CHECKER_TIMEOUT_EN is defined.
module riscv_test_checker
    import riscv_test_pkg::*;
#(
    parameter int  NUM_TEST     = 32,
    parameter int  DWIDTH       = 32,
    parameter int  CWIDTH       = 32,
    parameter int  STOP_ON_FAIL = 1,
    parameter int  TIMEOUT      = 1000000,
    localparam int IW           = (NUM_TEST > 1) ? $clog2(NUM_TEST) : 1,
    localparam int CNTW         = $clog2(NUM_TEST) + 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              TBL_WE,
    input  logic [IW-1:0]     TBL_IDX,
    input  logic [CWIDTH-1:0] TBL_NUM_INST,
    input  logic [DWIDTH-1:0] TBL_ANS,
    input  logic              TBL_VALID,
    input  logic              START,
    input  logic [CWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [1:0]        FAIL_CODE,
    output logic [IW-1:0]     FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_VALUE,
    output logic [CNTW-1:0]   PASS_CNT,
    output logic [CWIDTH-1:0] CYCLE
);

    localparam logic [CWIDTH-1:0] TIMEOUT_LIM = CWIDTH'(TIMEOUT);

    state_t                            state, state_nxt;
    logic [NUM_TEST-1:0][CWIDTH-1:0]   ent_num_inst;
    logic [NUM_TEST-1:0][DWIDTH-1:0]   ent_ans;
    logic [NUM_TEST-1:0]               ent_valid;
    logic [NUM_TEST-1:0]               checked;
    logic [NUM_TEST-1:0]               hit, match_vec, mis_vec, unchecked;
    logic [CNTW-1:0]                   match_cnt;
    logic [IW-1:0]                     mis_lo, miss_lo;
    logic                              any_mis, mis_seen, mis_seen_nxt, arm;
    logic [CWIDTH-1:0]                 cycle_inc;
    logic [1:0]                        fail_code_nxt;
    logic [IW-1:0]                     fail_idx_nxt;
    logic [DWIDTH-1:0]                 fail_value_nxt;

    riscv_test_table #(
        .NUM_TEST (NUM_TEST),
        .DWIDTH   (DWIDTH),
        .CWIDTH   (CWIDTH),
        .IW       (IW)
    ) u_table (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .wr_en        (TBL_WE && (state != ST_RUN)),
        .wr_idx       (TBL_IDX),
        .wr_num_inst  (TBL_NUM_INST),
        .wr_ans       (TBL_ANS),
        .wr_valid     (TBL_VALID),
        .ent_num_inst (ent_num_inst),
        .ent_ans      (ent_ans),
        .ent_valid    (ent_valid)
    );

    assign arm       = START && (state != ST_RUN);
    assign cycle_inc = (&CYCLE) ? CYCLE : CYCLE + CWIDTH'(1);
    assign any_mis   = |mis_vec;

    // Parallel compare of every pending entry, plus lowest-index encoders for failure reporting.
    always_comb begin
        hit       = '0;
        match_vec = '0;
        mis_vec   = '0;
        match_cnt = '0;
        mis_lo    = '0;
        miss_lo   = '0;
        for (int i = 0; i < NUM_TEST; i++) begin
            hit[i]       = (state == ST_RUN) && ent_valid[i] && !checked[i] &&
                           (ent_num_inst[i] == NUM_INST);
            match_vec[i] = hit[i] && (ent_ans[i] == OUTPUT_PORT);
            mis_vec[i]   = hit[i] && (ent_ans[i] != OUTPUT_PORT);
            if (match_vec[i]) match_cnt = match_cnt + CNTW'(1);
        end
        unchecked = ent_valid & ~(checked | hit);
        for (int i = NUM_TEST - 1; i >= 0; i--) begin
            if (mis_vec[i])   mis_lo  = IW'(i);
            if (unchecked[i]) miss_lo = IW'(i);
        end
    end

    always_comb begin
        state_nxt      = state;
        fail_code_nxt  = FAIL_CODE;
        fail_idx_nxt   = FAIL_IDX;
        fail_value_nxt = FAIL_VALUE;
        mis_seen_nxt   = mis_seen;
        case (state)
            ST_RUN: begin
                if (any_mis && !mis_seen) begin
                    fail_code_nxt  = FC_MISMATCH;
                    fail_idx_nxt   = mis_lo;
                    fail_value_nxt = OUTPUT_PORT;
                    mis_seen_nxt   = 1'b1;
                end
                if (any_mis && (STOP_ON_FAIL != 0)) begin
                    state_nxt = ST_FAIL;
                end else if (HALT) begin
                    // A recorded mismatch outranks a missed checkpoint.
                    if (mis_seen || any_mis) begin
                        state_nxt = ST_FAIL;
                    end else if (|unchecked) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = FC_MISSED;
                        fail_idx_nxt  = miss_lo;
                    end else begin
                        state_nxt = ST_PASS;
                    end
                end
`ifdef RISCV_TEST_CHECKER_TIMEOUT_EN
                else if (cycle_inc == TIMEOUT_LIM) begin
                    state_nxt = ST_FAIL;
                    if (!(mis_seen || any_mis)) begin
                        fail_code_nxt = FC_TIMEOUT;
                        fail_idx_nxt  = '0;
                    end
                end
`endif
            end
            default: begin
                if (START) state_nxt = ST_RUN;
            end
        endcase
    end

`ifndef RISCV_TEST_CHECKER_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_LIM;
`endif

    // Status flags are decoded from the next state so they stay registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
        end else begin
            state <= state_nxt;
            BUSY  <= (state_nxt == ST_RUN);
            DONE  <= (state_nxt == ST_PASS) || (state_nxt == ST_FAIL);
            PASS  <= (state_nxt == ST_PASS);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            checked    <= '0;
            mis_seen   <= 1'b0;
            PASS_CNT   <= '0;
            CYCLE      <= '0;
            FAIL_CODE  <= FC_NONE;
            FAIL_IDX   <= '0;
            FAIL_VALUE <= '0;
        end else if (arm) begin
            checked    <= '0;
            mis_seen   <= 1'b0;
            PASS_CNT   <= '0;
            CYCLE      <= '0;
            FAIL_CODE  <= FC_NONE;
            FAIL_IDX   <= '0;
            FAIL_VALUE <= '0;
        end else if (state == ST_RUN) begin
            checked    <= checked | hit;
            mis_seen   <= mis_seen_nxt;
            PASS_CNT   <= PASS_CNT + match_cnt;
            CYCLE      <= cycle_inc;
            FAIL_CODE  <= fail_code_nxt;
            FAIL_IDX   <= fail_idx_nxt;
            FAIL_VALUE <= fail_value_nxt;
        end
    end

endmodule

// File: tb/tb_riscv_test_checker.sv
// Directed bench for riscv_test_checker: two instances (STOP_ON_FAIL=1 as "a", =0 as "b").
// Watchdog expectations follow RISCV_TEST_CHECKER_TIMEOUT_EN.
module tb_riscv_test_checker;

    localparam int NT = 3;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam int IW = 2;
    localparam int PW = 3;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          tbl_we = 1'b0;
    logic [IW-1:0] tbl_idx = '0;
    logic [CW-1:0] tbl_num_inst = '0;
    logic [DW-1:0] tbl_ans = '0;
    logic          tbl_valid = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_inst = '0;
    logic [DW-1:0] output_port = '0;
    logic          halt = 1'b0;

    logic          busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [1:0]    fail_code_a, fail_code_b;
    logic [IW-1:0] fail_idx_a, fail_idx_b;
    logic [DW-1:0] fail_value_a, fail_value_b;
    logic [PW-1:0] pass_cnt_a, pass_cnt_b;
    logic [CW-1:0] cycle_a, cycle_b;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    riscv_test_checker #(
        .NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW), .STOP_ON_FAIL(1), .TIMEOUT(20)
    ) dut_a (
        .CLK(CLK), .RSTn(RSTn), .TBL_WE(tbl_we), .TBL_IDX(tbl_idx),
        .TBL_NUM_INST(tbl_num_inst), .TBL_ANS(tbl_ans), .TBL_VALID(tbl_valid),
        .START(start), .NUM_INST(num_inst), .OUTPUT_PORT(output_port), .HALT(halt),
        .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .FAIL_CODE(fail_code_a),
        .FAIL_IDX(fail_idx_a), .FAIL_VALUE(fail_value_a), .PASS_CNT(pass_cnt_a),
        .CYCLE(cycle_a)
    );

    riscv_test_checker #(
        .NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW), .STOP_ON_FAIL(0), .TIMEOUT(20)
    ) dut_b (
        .CLK(CLK), .RSTn(RSTn), .TBL_WE(tbl_we), .TBL_IDX(tbl_idx),
        .TBL_NUM_INST(tbl_num_inst), .TBL_ANS(tbl_ans), .TBL_VALID(tbl_valid),
        .START(start), .NUM_INST(num_inst), .OUTPUT_PORT(output_port), .HALT(halt),
        .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .FAIL_CODE(fail_code_b),
        .FAIL_IDX(fail_idx_b), .FAIL_VALUE(fail_value_b), .PASS_CNT(pass_cnt_b),
        .CYCLE(cycle_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [CW-1:0] ni,
                                 input logic [DW-1:0] op, input logic h);
        start       = st;
        num_inst    = ni;
        output_port = op;
        halt        = h;
        tick();
        start = 1'b0;
        halt  = 1'b0;
    endtask

    task automatic writeEntry(input logic [IW-1:0] idx, input logic [CW-1:0] n,
                              input logic [DW-1:0] ans, input logic v);
        tbl_we       = 1'b1;
        tbl_idx      = idx;
        tbl_num_inst = n;
        tbl_ans      = ans;
        tbl_valid    = v;
        tick();
        tbl_we = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        checkOutput("rst_busy", 64'(busy_a), 64'd0);
        checkOutput("rst_done", 64'(done_a), 64'd0);
        checkOutput("rst_pass", 64'(pass_a), 64'd0);
        checkOutput("rst_code", 64'(fail_code_a), 64'd0);
        checkOutput("rst_idx", 64'(fail_idx_a), 64'd0);
        checkOutput("rst_value", 64'(fail_value_a), 64'd0);
        checkOutput("rst_pcnt", 64'(pass_cnt_a), 64'd0);
        checkOutput("rst_cycle", 64'(cycle_a), 64'd0);
        RSTn = 1'b1;

        writeEntry(2'd0, 32'd1, 32'h0, 1'b1);
        writeEntry(2'd1, 32'd3, 32'h5, 1'b1);
        writeEntry(2'd2, 32'd11, 32'h1e, 1'b1);

        // Clean run; final checkpoint coincides with HALT
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        checkOutput("t1_busy", 64'(busy_a), 64'd1);
        checkOutput("t1_cycle0", 64'(cycle_a), 64'd0);
        for (int n = 1; n <= 10; n++) begin
            applyStimulus(1'b0, 32'(n), (n == 1) ? 32'h0 : (n == 3) ? 32'h5 : 32'(n) + 32'h100, 1'b0);
        end
        checkOutput("t1_pcnt10", 64'(pass_cnt_a), 64'd2);
        checkOutput("t1_cycle10", 64'(cycle_a), 64'd10);
        applyStimulus(1'b0, 32'd11, 32'h1e, 1'b1);
        checkOutput("t1_done", 64'(done_a), 64'd1);
        checkOutput("t1_pass", 64'(pass_a), 64'd1);
        checkOutput("t1_busy_end", 64'(busy_a), 64'd0);
        checkOutput("t1_pcnt", 64'(pass_cnt_a), 64'd3);
        checkOutput("t1_code", 64'(fail_code_a), 64'd0);
        checkOutput("t1_cycle", 64'(cycle_a), 64'd11);
        checkOutput("t1_pass_b", 64'(pass_b), 64'd1);

        // Mismatch at entry 1
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        checkOutput("t2_rearm_pcnt", 64'(pass_cnt_a), 64'd0);
        checkOutput("t2_rearm_done", 64'(done_a), 64'd0);
        applyStimulus(1'b0, 32'd1, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd3, 32'h4, 1'b0);
        checkOutput("t2_done", 64'(done_a), 64'd1);
        checkOutput("t2_code", 64'(fail_code_a), 64'd1);
        checkOutput("t2_idx", 64'(fail_idx_a), 64'd1);
        checkOutput("t2_value", 64'(fail_value_a), 64'h4);
        checkOutput("t2_pcnt", 64'(pass_cnt_a), 64'd1);
        checkOutput("t2_busy_b", 64'(busy_b), 64'd1);
        checkOutput("t2_value_b", 64'(fail_value_b), 64'h4);
        applyStimulus(1'b0, 32'd11, 32'h1e, 1'b1);
        checkOutput("t2_halt_code", 64'(fail_code_a), 64'd1);
        checkOutput("t2_halt_pass", 64'(pass_a), 64'd0);
        checkOutput("t2_halt_pcnt", 64'(pass_cnt_a), 64'd1);
        checkOutput("t2_halt_code_b", 64'(fail_code_b), 64'd1);
        checkOutput("t2_halt_pcnt_b", 64'(pass_cnt_b), 64'd2);

        // Two mismatches, STOP_ON_FAIL=0 keeps running and records only the first
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd1, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd3, 32'h6, 1'b0);
        checkOutput("t3_busy_b", 64'(busy_b), 64'd1);
        checkOutput("t3_idx_b", 64'(fail_idx_b), 64'd1);
        applyStimulus(1'b0, 32'd11, 32'h1f, 1'b0);
        checkOutput("t3_busy_b2", 64'(busy_b), 64'd1);
        checkOutput("t3_value_b", 64'(fail_value_b), 64'h6);
        applyStimulus(1'b0, 32'd12, 32'h0, 1'b1);
        checkOutput("t3_code_b", 64'(fail_code_b), 64'd1);
        checkOutput("t3_idx_b_end", 64'(fail_idx_b), 64'd1);
        checkOutput("t3_pcnt_b", 64'(pass_cnt_b), 64'd1);
        checkOutput("t3_done_b", 64'(done_b), 64'd1);

        // Missed checkpoint
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd1, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd3, 32'h5, 1'b0);
        applyStimulus(1'b0, 32'd5, 32'h0, 1'b1);
        checkOutput("t4_code", 64'(fail_code_a), 64'd2);
        checkOutput("t4_idx", 64'(fail_idx_a), 64'd2);
        checkOutput("t4_pcnt", 64'(pass_cnt_a), 64'd2);
        checkOutput("t4_code_b", 64'(fail_code_b), 64'd2);

        // Watchdog
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        repeat (19) applyStimulus(1'b0, 32'd0, 32'h0, 1'b0);
        checkOutput("t5_busy19", 64'(busy_a), 64'd1);
        checkOutput("t5_cycle19", 64'(cycle_a), 64'd19);
        applyStimulus(1'b0, 32'd0, 32'h0, 1'b0);
        checkOutput("t5_cycle20", 64'(cycle_a), 64'd20);
`ifdef RISCV_TEST_CHECKER_TIMEOUT_EN
        checkOutput("t5_done", 64'(done_a), 64'd1);
        checkOutput("t5_code", 64'(fail_code_a), 64'd3);
        checkOutput("t5_idx", 64'(fail_idx_a), 64'd0);
        checkOutput("t5_code_b", 64'(fail_code_b), 64'd3);
`else
        checkOutput("t5_busy20", 64'(busy_a), 64'd1);
        checkOutput("t5_code_none", 64'(fail_code_a), 64'd0);
        applyStimulus(1'b0, 32'd0, 32'h0, 1'b1);
        checkOutput("t5_halt_code", 64'(fail_code_a), 64'd2);
        checkOutput("t5_halt_idx", 64'(fail_idx_a), 64'd0);
`endif

        // START while busy, table write while busy, async reset mid-run
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        checkOutput("t6_start_ignored", 64'(cycle_a), 64'd2);
        writeEntry(2'd1, 32'd3, 32'h77, 1'b1);
        applyStimulus(1'b0, 32'd3, 32'h5, 1'b0);
        checkOutput("t6_we_dropped", 64'(pass_cnt_a), 64'd1);
        checkOutput("t6_busy_pre", 64'(busy_a), 64'd1);
        #2 RSTn = 1'b0;
        #1;
        checkOutput("t6_rst_busy", 64'(busy_a), 64'd0);
        checkOutput("t6_rst_cycle", 64'(cycle_a), 64'd0);
        checkOutput("t6_rst_pcnt", 64'(pass_cnt_a), 64'd0);
        checkOutput("t6_rst_done", 64'(done_a), 64'd0);
        #2 RSTn = 1'b1;

        // Empty table after reset
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'h0, 1'b1);
        checkOutput("t7_pass", 64'(pass_a), 64'd1);
        checkOutput("t7_pcnt", 64'(pass_cnt_a), 64'd0);
        checkOutput("t7_pass_b", 64'(pass_b), 64'd1);

        // Same checkpoint in every entry: lowest mismatching index is reported
        writeEntry(2'd0, 32'd7, 32'ha, 1'b1);
        writeEntry(2'd1, 32'd7, 32'hb, 1'b1);
        writeEntry(2'd2, 32'd7, 32'hc, 1'b1);
        writeEntry(2'd3, 32'd7, 32'hd, 1'b1);
        applyStimulus(1'b1, 32'd0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'd7, 32'hc, 1'b0);
        checkOutput("t8_code", 64'(fail_code_a), 64'd1);
        checkOutput("t8_idx", 64'(fail_idx_a), 64'd0);
        checkOutput("t8_busy_b", 64'(busy_b), 64'd1);
        checkOutput("t8_value_b", 64'(fail_value_b), 64'hc);
        checkOutput("t8_pcnt_b", 64'(pass_cnt_b), 64'd1);
        applyStimulus(1'b0, 32'd7, 32'h0, 1'b1);
        checkOutput("t8_halt_code_b", 64'(fail_code_b), 64'd1);
        checkOutput("t8_halt_idx_b", 64'(fail_idx_b), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_test_checker.md
# riscv_test_checker

Synthesizable, parametrised self-checking monitor for the pipelined/cached RISC-V core. It holds a programmable table of (retired-instruction-count, expected OUTPUT_PORT) checkpoints and compares the core's OUTPUT_PORT whenever NUM_INST hits a checkpoint. It tracks per-entry pass/fail, detects HALT, optionally enforces a cycle watchdog, and reports a registered verdict. It sits beside RISCV_TOP in benches and FPGA bring-up, replacing hand-written check loops.

## Interface
- NUM_TEST, 32: number of table entries (1..256)
- DWIDTH, 32: width of OUTPUT_PORT and of the expected answer
- CWIDTH, 32: width of NUM_INST, the table instruction counts and CYCLE
- STOP_ON_FAIL, 1: 1 = finish on first mismatch; 0 = keep running and count failures
- TIMEOUT, 1000000: watchdog limit in RUN cycles (used only when the watchdog is compiled in)
- CLK  in  1  clock; all state updates on rising edge
- RSTn  in  1  asynchronous active-low reset
- TBL_WE  in  1  table write strobe; honoured only outside RUN
- TBL_IDX  in  $clog2(NUM_TEST)  entry index; indices >= NUM_TEST are ignored
- TBL_NUM_INST  in  CWIDTH  checkpoint instruction count
- TBL_ANS  in  DWIDTH  expected OUTPUT_PORT value
- TBL_VALID  in  1  entry-valid bit written with the entry
- START  in  1  single-cycle pulse that arms a run
- NUM_INST  in  CWIDTH  retired-instruction count from the core
- OUTPUT_PORT  in  DWIDTH  core output port
- HALT  in  1  core halt flag
- BUSY  out  1  high in RUN
- DONE  out  1  high in PASS or FAIL
- PASS  out  1  run finished with every valid entry checked and matched
- FAIL_CODE  out  2  0 none, 1 mismatch, 2 missed checkpoint, 3 timeout
- FAIL_IDX  out  $clog2(NUM_TEST)  lowest index that caused the failure
- FAIL_VALUE  out  DWIDTH  OUTPUT_PORT sampled at the first mismatch
- PASS_CNT  out  $clog2(NUM_TEST)+1  entries matched in this run
- CYCLE  out  CWIDTH  RUN cycles elapsed (saturating)

## Operation
- FSM states: IDLE, RUN, PASS, FAIL. Reset puts it in IDLE.
- IDLE → RUN on START. Entering RUN clears the checked/passed bitmaps, PASS_CNT, CYCLE, FAIL_CODE, FAIL_IDX and FAIL_VALUE. The table contents are retained.
- Each RUN cycle, every valid entry that is not yet checked and has TBL_NUM_INST == NUM_INST is checked in parallel:
  - Entry is marked checked.
  - Equal to OUTPUT_PORT: marked passed and counted in PASS_CNT.
  - Not equal: mismatch. On the first mismatch only, record FAIL_IDX = lowest mismatching index and FAIL_VALUE = OUTPUT_PORT.
- Any mismatch with STOP_ON_FAIL=1: → FAIL with code 1.
- HALT in RUN ends the run:
  - Any valid entry left unchecked: → FAIL with code 2, FAIL_IDX = lowest unchecked index, unless a mismatch was already recorded (code 1 keeps priority).
  - Any recorded mismatch: → FAIL with code 1.
  - Otherwise → PASS.
- PASS/FAIL → RUN on START (re-arm). The only exit to IDLE is reset.
- Table writes while BUSY are dropped.
- START while BUSY is ignored.
- An empty table (no valid entries) followed by HALT → PASS.

## Timing
- All outputs are registered.
- Reset values: BUSY=0, DONE=0, PASS=0, FAIL_CODE=0, FAIL_IDX=0, FAIL_VALUE=0, PASS_CNT=0, CYCLE=0. The table is cleared to all entries invalid.
- START sampled high at edge N: BUSY=1 after edge N. NUM_INST/OUTPUT_PORT are first compared at edge N+1.
- A match or mismatch sampled at edge K is visible on PASS_CNT/FAIL_* after edge K. The verdict (DONE) is also visible after edge K, so latency is 1 cycle.
- If HALT and a checkpoint match occur at the same edge, the match is evaluated first and the verdict then includes it.
- CYCLE increments on every RUN edge and saturates at all-ones.
- A table write at edge N is readable from edge N+1.
- Asserting RSTn low mid-run immediately clears the FSM and all outputs, with no clock edge needed.

## Configuration
- `RISCV_TEST_CHECKER_TIMEOUT_EN` defined:
  - In RUN, when CYCLE reaches TIMEOUT without HALT → FAIL with code 3 and FAIL_IDX = 0.
  - A checkpoint evaluated at the same edge is still recorded. Mismatch code 1 wins over timeout.
- Not defined: no watchdog logic is built, FAIL_CODE never equals 3, and TIMEOUT is unused.

## Structure
- Shared package riscv_test_pkg holds:
  - State enum (IDLE/RUN/PASS/FAIL).
  - FAIL_CODE constants (FC_NONE, FC_MISMATCH, FC_MISSED, FC_TIMEOUT).
- Sub-module riscv_test_table: the NUM_TEST-entry register array with its write port. It exposes all entries in parallel to the compare logic.
- The top module contains the FSM, the bitmaps, the lowest-index priority encoder and the counters.

## Test plan
- Load entries {1:0x0}, {3:0x5}, {11:0x1e}; START; drive NUM_INST 1..11 with matching OUTPUT_PORT, then HALT → PASS=1, PASS_CNT=3, FAIL_CODE=0.
- Same table, STOP_ON_FAIL=1, OUTPUT_PORT=0x4 at NUM_INST=3 → FAIL one cycle later, FAIL_CODE=1, FAIL_IDX=1, FAIL_VALUE=0x4; HALT afterwards has no effect.
- STOP_ON_FAIL=0, entries 1 and 2 both mismatch → run continues; at HALT FAIL_CODE=1, FAIL_IDX=1, PASS_CNT=1.
- HALT at NUM_INST=5 with entry {11:0x1e} unchecked → FAIL_CODE=2, FAIL_IDX=2.
- Macro defined, TIMEOUT=20, HALT never asserted → FAIL_CODE=3 after the 20th RUN cycle, CYCLE=20.
- RSTn low during RUN → all outputs 0 and state IDLE immediately; a TBL_WE issued while BUSY leaves the entry unchanged.
